multichannel_boxcar_decimator: RTL and testbench

Parametrised multi-channel boxcar (sum-and-dump) decimator for DSBPM magnitude streams. It generates turn-by-turn, FA and SA rate data from per-sample magnitudes.
- Channel count, data width and maximum decimation are set by parameters.
- Decimation factor is programmable at runtime.
- Output is either the raw sum or a shifted average.
- A sync input realigns the decimation window to an external marker (turn, FA or SA), and misalignment is reported in a sticky status bit.

---
 rtl/multichannel_boxcar_decimator.sv | 153 +++++++++++++++
 tb/tb_multichannel_boxcar_decimator.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/multichannel_boxcar_decimator.sv
// ---------------------------------------------------------------------------
// multichannel_boxcar_decimator
//
// Sum-and-dump decimator for DSBPM magnitude streams. Every channel sums
// N consecutive accepted samples and dumps the result once per window,
// either as the raw sum or as the sum shifted right (average mode). A sync
// marker on an accepted sample always restarts the window. If the window
// was only partly filled, that partial window is dropped and a sticky
// error is raised.
//
// Ports:
//   clk            - single clock, all logic synchronous to it
//   rst_n          - synchronous active-low reset
//   decimateFactor - samples per window (0/1 -> 1, clamped to MAX_DECIMATE)
//   avgMode        - 0: output raw sum, 1: output sum >> avgShift
//   avgShift       - right shift used in average mode
//   clrStatus      - one-cycle pulse clearing syncErr
//   inData         - packed unsigned samples, channel n at [n*DATA_WIDTH +: DATA_WIDTH]
//   inValid        - qualifies inData and inSync
//   inSync         - window-alignment marker (only honoured with inValid)
//   outData        - packed results, channel n at [n*SUM_WIDTH +: SUM_WIDTH]
//   outValid       - one-cycle strobe per completed window
//   outSeq         - running window count carried with each strobe
//   syncErr        - sticky flag: sync arrived mid-window
// ---------------------------------------------------------------------------
module multichannel_boxcar_decimator #(
    parameter int CHANNEL_COUNT  = 8,
    parameter int DATA_WIDTH     = 26,
    parameter int MAX_DECIMATE   = 2000,
    parameter int DECIMATE_WIDTH = $clog2(MAX_DECIMATE + 1),
    parameter int SUM_WIDTH      = DATA_WIDTH + $clog2(MAX_DECIMATE),
    parameter int SHIFT_WIDTH    = 5,
    parameter int SEQ_WIDTH      = 16
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [DECIMATE_WIDTH-1:0]          decimateFactor,
    input  logic                               avgMode,
    input  logic [SHIFT_WIDTH-1:0]             avgShift,
    input  logic                               clrStatus,
    input  logic [CHANNEL_COUNT*DATA_WIDTH-1:0] inData,
    input  logic                               inValid,
    input  logic                               inSync,
    output logic [CHANNEL_COUNT*SUM_WIDTH-1:0] outData,
    output logic                               outValid,
    output logic [SEQ_WIDTH-1:0]               outSeq,
    output logic                               syncErr
);

    localparam logic [DECIMATE_WIDTH-1:0] MAX_N = DECIMATE_WIDTH'(MAX_DECIMATE);
    localparam logic [DECIMATE_WIDTH-1:0] ONE_N = DECIMATE_WIDTH'(1);

    logic [SUM_WIDTH-1:0]               acc_q [CHANNEL_COUNT];
    logic [SUM_WIDTH-1:0]               acc_d [CHANNEL_COUNT];
    logic [DECIMATE_WIDTH-1:0]          count_q, count_d;
    logic [DECIMATE_WIDTH-1:0]          active_n_q, active_n_d;
    logic [CHANNEL_COUNT*SUM_WIDTH-1:0] out_data_q, out_data_d;
    logic                               out_valid_q, out_valid_d;
    logic [SEQ_WIDTH-1:0]               out_seq_q, out_seq_d;
    logic                               sync_err_q, sync_err_d;

    logic [DECIMATE_WIDTH-1:0]          eff_n;
    logic [DECIMATE_WIDTH-1:0]          win_n;
    logic [DECIMATE_WIDTH-1:0]          next_count;
    logic                               win_start;
    logic                               win_done;
    logic                               sync_miss;

    // Sanitised factor: 0 and 1 both mean "every sample", oversize clamps.
    always_comb begin
        eff_n = decimateFactor;
        if (decimateFactor <= ONE_N) begin
            eff_n = ONE_N;
        end else if (decimateFactor > MAX_N) begin
            eff_n = MAX_N;
        end
    end

    // A sample opens a new window when the previous one was dumped or when
    // sync forces a restart. The window length is relatched at that point, so
    // a factor change mid-window only takes effect on the following window.
    assign win_start  = inValid && (inSync || (count_q == '0));
    assign win_n      = win_start ? eff_n : active_n_q;
    assign next_count = win_start ? ONE_N : count_q + ONE_N;
    assign win_done   = inValid && (next_count == win_n);
    assign sync_miss  = inValid && inSync && (count_q != '0);

    always_comb begin
        acc_d       = acc_q;
        count_d     = count_q;
        active_n_d  = active_n_q;
        out_data_d  = out_data_q;
        out_valid_d = 1'b0;
        out_seq_d   = out_seq_q;
        sync_err_d  = sync_err_q;

        if (inValid) begin
            for (int n = 0; n < CHANNEL_COUNT; n++) begin
                acc_d[n] = (win_start ? '0 : acc_q[n])
                         + SUM_WIDTH'(inData[n*DATA_WIDTH +: DATA_WIDTH]);
            end
            active_n_d = win_n;
            if (win_done) begin
                // Dump the sum including the current sample; the stale acc
                // contents are overwritten by the next window-start sample.
                count_d     = '0;
                out_valid_d = 1'b1;
                out_seq_d   = out_seq_q + SEQ_WIDTH'(1);
                for (int n = 0; n < CHANNEL_COUNT; n++) begin
                    out_data_d[n*SUM_WIDTH +: SUM_WIDTH] =
                        avgMode ? (acc_d[n] >> avgShift) : acc_d[n];
                end
            end else begin
                count_d = next_count;
            end
        end

        // A new error wins over a simultaneous clear request.
        if (sync_miss) begin
            sync_err_d = 1'b1;
        end else if (clrStatus) begin
            sync_err_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int n = 0; n < CHANNEL_COUNT; n++) begin
                acc_q[n] <= '0;
            end
            count_q     <= '0;
            active_n_q  <= ONE_N;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_seq_q   <= '0;
            sync_err_q  <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            count_q     <= count_d;
            active_n_q  <= active_n_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_seq_q   <= out_seq_d;
            sync_err_q  <= sync_err_d;
        end
    end

    assign outData  = out_data_q;
    assign outValid = out_valid_q;
    assign outSeq   = out_seq_q;
    assign syncErr  = sync_err_q;

endmodule

// File: tb/tb_multichannel_boxcar_decimator.sv
// ---------------------------------------------------------------------------
// tb_multichannel_boxcar_decimator
//
// Self-checking bench for multichannel_boxcar_decimator. A reference model
// keeps the current window as a queue of whole input vectors and sums it
// with plain arithmetic when the window fills. Every cycle the four outputs
// are compared against the model's prediction. Directed scenarios come
// first, followed by a randomized soak.
// ---------------------------------------------------------------------------
module tb_multichannel_boxcar_decimator;

    localparam int CH   = 8;
    localparam int DW   = 26;
    localparam int MAXD = 2000;
    localparam int DECW = $clog2(MAXD + 1);
    localparam int SUMW = DW + $clog2(MAXD);
    localparam int SHW  = 5;
    localparam int SEQW = 16;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [DECW-1:0]      decimateFactor;
    logic                 avgMode;
    logic [SHW-1:0]       avgShift;
    logic                 clrStatus;
    logic [CH*DW-1:0]     inData;
    logic                 inValid;
    logic                 inSync;
    logic [CH*SUMW-1:0]   outData;
    logic                 outValid;
    logic [SEQW-1:0]      outSeq;
    logic                 syncErr;

    int assertCount = 0;
    int failCount   = 0;

    // Reference model state
    logic [CH*DW-1:0]     winQ[$];
    int                   winN;
    logic [SEQW-1:0]      mSeq;
    logic                 mErr;
    logic                 mValid;
    logic [CH*SUMW-1:0]   mData;

    multichannel_boxcar_decimator #(
        .CHANNEL_COUNT (CH),
        .DATA_WIDTH    (DW),
        .MAX_DECIMATE  (MAXD),
        .DECIMATE_WIDTH(DECW),
        .SUM_WIDTH     (SUMW),
        .SHIFT_WIDTH   (SHW),
        .SEQ_WIDTH     (SEQW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .decimateFactor(decimateFactor),
        .avgMode       (avgMode),
        .avgShift      (avgShift),
        .clrStatus     (clrStatus),
        .inData        (inData),
        .inValid       (inValid),
        .inSync        (inSync),
        .outData       (outData),
        .outValid      (outValid),
        .outSeq        (outSeq),
        .syncErr       (syncErr)
    );

    always #5 clk = ~clk;

    function automatic int effFactor(input int df);
        if (df <= 1) return 1;
        if (df > MAXD) return MAXD;
        return df;
    endfunction

    function automatic logic [CH*DW-1:0] randData();
        logic [CH*DW-1:0] r;
        for (int n = 0; n < CH; n++) r[n*DW +: DW] = DW'($urandom);
        return r;
    endfunction

    task automatic modelReset();
        winQ.delete();
        winN   = 1;
        mSeq   = '0;
        mErr   = 1'b0;
        mValid = 1'b0;
        mData  = '0;
    endtask

    task automatic checkOutput(input string tag);
        assertCount++;
        assert (outValid === mValid) else begin
            failCount++;
            $error("[TB] FAIL %s outValid observed=%0b expected=%0b", tag, outValid, mValid);
        end
        assertCount++;
        assert (outData === mData) else begin
            failCount++;
            $error("[TB] FAIL %s outData observed=%h expected=%h", tag, outData, mData);
        end
        assertCount++;
        assert (outSeq === mSeq) else begin
            failCount++;
            $error("[TB] FAIL %s outSeq observed=%0d expected=%0d", tag, outSeq, mSeq);
        end
        assertCount++;
        assert (syncErr === mErr) else begin
            failCount++;
            $error("[TB] FAIL %s syncErr observed=%0b expected=%0b", tag, syncErr, mErr);
        end
    endtask

    // Drive one cycle of inputs, advance the model by the same sample, then
    // compare just after the clock edge.
    task automatic applyStimulus(input logic v, input logic s, input logic clr,
                                 input logic [CH*DW-1:0] d, input string tag);
        bit errSet;
        inValid   = v;
        inSync    = s;
        clrStatus = clr;
        inData    = d;

        errSet = 1'b0;
        mValid = 1'b0;
        if (v) begin
            if (s || winQ.size() == 0) begin
                errSet = s && (winQ.size() != 0);
                winQ.delete();
                winN = effFactor(int'(decimateFactor));
            end
            winQ.push_back(d);
            if (winQ.size() == winN) begin
                for (int n = 0; n < CH; n++) begin
                    longint sum;
                    sum = 0;
                    foreach (winQ[k]) sum += longint'(winQ[k][n*DW +: DW]);
                    if (avgMode) sum = sum >> avgShift;
                    mData[n*SUMW +: SUMW] = sum[SUMW-1:0];
                end
                mValid = 1'b1;
                mSeq   = mSeq + SEQW'(1);
                winQ.delete();
            end
        end
        if (errSet) mErr = 1'b1;
        else if (clr) mErr = 1'b0;

        @(posedge clk);
        #1;
        checkOutput(tag);
    endtask

    // Reset is held with live-looking inputs to show they are ignored.
    task automatic applyReset(input int cycles);
        rst_n     = 1'b0;
        inValid   = 1'b1;
        inSync    = 1'b1;
        clrStatus = 1'b0;
        inData    = randData();
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            modelReset();
            checkOutput("reset");
        end
        rst_n   = 1'b1;
        inValid = 1'b0;
        inSync  = 1'b0;
    endtask

    initial begin
        logic [CH*DW-1:0] d;
        longint           expAll;

        rst_n          = 1'b0;
        inValid        = 1'b0;
        inSync         = 1'b0;
        clrStatus      = 1'b0;
        inData         = '0;
        decimateFactor = DECW'(4);
        avgMode        = 1'b0;
        avgShift       = '0;
        modelReset();

        $display("[TB] reset");
        applyReset(3);

        $display("[TB] N=4 constant 10 on channel 0");
        d = '0;
        d[0 +: DW] = DW'(10);
        repeat (12) applyStimulus(1'b1, 1'b0, 1'b0, d, "t1_const10");

        $display("[TB] N=8 average mode, channel n = (n+1)*100");
        decimateFactor = DECW'(8);
        avgMode        = 1'b1;
        avgShift       = SHW'(3);
        for (int n = 0; n < CH; n++) d[n*DW +: DW] = DW'((n + 1) * 100);
        repeat (16) applyStimulus(1'b1, 1'b0, 1'b0, d, "t2_shift3");
        avgShift = SHW'(2);
        repeat (8) applyStimulus(1'b1, 1'b0, 1'b0, d, "t2_shift2");

        $display("[TB] N=5 with gapped inValid");
        decimateFactor = DECW'(5);
        avgMode        = 1'b0;
        for (int i = 0; i < 20; i++)
            applyStimulus(i % 2 == 0, 1'b0, 1'b0, randData(), "t3_gapped");

        $display("[TB] sync handling");
        decimateFactor = DECW'(4);
        repeat (2) applyStimulus(1'b1, 1'b0, 1'b0, randData(), "t4_pre");
        applyStimulus(1'b1, 1'b1, 1'b0, randData(), "t4_sync_mid");
        repeat (3) applyStimulus(1'b1, 1'b0, 1'b0, randData(), "t4_post");
        applyStimulus(1'b0, 1'b0, 1'b1, randData(), "t4_clear");
        applyStimulus(1'b0, 1'b1, 1'b0, randData(), "t4_sync_novalid");
        applyStimulus(1'b1, 1'b1, 1'b0, randData(), "t4_sync_aligned");
        repeat (3) applyStimulus(1'b1, 1'b0, 1'b0, randData(), "t4_aligned_win");
        repeat (3) applyStimulus(1'b1, 1'b0, 1'b0, randData(), "t4_partial");
        applyStimulus(1'b1, 1'b1, 1'b1, randData(), "t4_sync_on_last_with_clr");
        repeat (3) applyStimulus(1'b1, 1'b0, 1'b0, randData(), "t4_after");

        $display("[TB] factor boundaries");
        decimateFactor = '0;
        repeat (5) applyStimulus(1'b1, 1'b0, 1'b0, randData(), "t5_factor0");
        decimateFactor = DECW'(1);
        repeat (3) applyStimulus(1'b1, 1'b0, 1'b0, randData(), "t5_factor1");
        decimateFactor = '1;
        d = '1;
        repeat (MAXD) applyStimulus(1'b1, 1'b0, 1'b0, d, "t5_allones_max");
        expAll = longint'(MAXD) * ((longint'(1) << DW) - 1);
        for (int n = 0; n < CH; n++) begin
            assertCount++;
            assert (outValid === 1'b1 && outData[n*SUMW +: SUMW] === expAll[SUMW-1:0]) else begin
                failCount++;
                $error("[TB] FAIL t5_allones_exact ch%0d observed=%h/%0b expected=%h/1",
                       n, outData[n*SUMW +: SUMW], outValid, expAll[SUMW-1:0]);
            end
        end
        applyStimulus(1'b0, 1'b0, 1'b0, randData(), "t5_hold");

        $display("[TB] factor change mid-window and reset mid-window");
        decimateFactor = DECW'(4);
        repeat (2) applyStimulus(1'b1, 1'b0, 1'b0, randData(), "t6_n4_first");
        decimateFactor = DECW'(6);
        repeat (2) applyStimulus(1'b1, 1'b0, 1'b0, randData(), "t6_n4_finish");
        repeat (6) applyStimulus(1'b1, 1'b0, 1'b0, randData(), "t6_n6");
        repeat (3) applyStimulus(1'b1, 1'b0, 1'b0, randData(), "t6_partial");
        applyReset(2);
        decimateFactor = DECW'(3);
        repeat (6) applyStimulus(1'b1, 1'b0, 1'b0, randData(), "t6_post_reset");

        $display("[TB] randomized soak");
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 15) == 0) decimateFactor = DECW'($urandom_range(0, 9));
            avgMode  = 1'($urandom_range(0, 1));
            avgShift = SHW'($urandom_range(0, 31));
            applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0,
                          $urandom_range(0, 7) == 0, randData(), "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
